// File: rtl/led_row_scanner.sv
// Time-multiplexed row scanner for an 8x8 board: blank/drive sequencing per row,
// with a one-deep pending board that is only swapped in at frame boundaries.
module led_row_scanner #(
    parameter int ROW_TICKS   = 1000,
    parameter int BLANK_TICKS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [63:0] board_in,
    input  logic        board_valid,
    output logic        board_ready,
    output logic [2:0]  row_sel,
    output logic        row_ena,
    output logic [7:0]  cols,
    output logic        frame_done,
    output logic [1:0]  state_dbg
);

    localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [63:0]   active_q, active_d;
    logic [63:0]   pending_q, pending_d;
    logic          pend_full_q, pend_full_d;
    logic          frame_done_q, frame_done_d;

    // Handshake: a board transfers on any edge where board_valid and board_ready
    // are both high; board_ready is simply "pending buffer empty".
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        tick_d       = tick_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_full_d  = pend_full_q;
        frame_done_d = 1'b0;

        if (!ena) begin
            state_d = IDLE;
            row_d   = 3'd0;
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    row_d   = 3'd0;
                    tick_d  = '0;
                end
                BLANK: begin
                    if (tick_q == TW'(BLANK_TICKS - 1)) begin
                        state_d = DRIVE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                DRIVE: begin
                    if (tick_q == TW'(ROW_TICKS - 1)) begin
                        state_d = BLANK;
                        row_d   = row_q + 3'd1;
                        tick_d  = '0;
                        // End of row 7 is the frame boundary: the only mid-scan swap point.
                        if (row_q == 3'd7) begin
                            frame_done_d = 1'b1;
                            if (pend_full_q) begin
                                active_d    = pending_q;
                                pend_full_d = 1'b0;
                            end
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = 3'd0;
                    tick_d  = '0;
                end
            endcase
        end

        if (state_q == IDLE && pend_full_q) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end

        // Capture only while empty, so it can never collide with a swap.
        if (board_valid && !pend_full_q) begin
            pending_d   = board_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= 3'd0;
            tick_q       <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_full_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            tick_q       <= tick_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_full_q  <= pend_full_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_ena     = (state_q == DRIVE);
    assign row_sel     = row_q;
    assign cols        = row_ena ? active_q[8*row_q +: 8] : 8'h00;
    assign frame_done  = frame_done_q;
    assign board_ready = ~pend_full_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_led_row_scanner.sv
// Self-checking bench for led_row_scanner (ROW_TICKS=4, BLANK_TICKS=2, 48-cycle frame).
module tb_led_row_scanner;

    localparam int RT    = 4;
    localparam int BT    = 2;
    localparam int RP    = RT + BT;
    localparam int FRAME = 8 * RP;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [63:0] board_in;
    logic        board_valid;
    logic        board_ready;
    logic [2:0]  row_sel;
    logic        row_ena;
    logic [7:0]  cols;
    logic        frame_done;
    logic [1:0]  state_dbg;

    led_row_scanner #(.ROW_TICKS(RT), .BLANK_TICKS(BT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .board_in    (board_in),
        .board_valid (board_valid),
        .board_ready (board_ready),
        .row_sel     (row_sel),
        .row_ena     (row_ena),
        .cols        (cols),
        .frame_done  (frame_done),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [13:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // spec-level model: position within the frame derived from cycles since start
    bit          m_run  = 1'b0;
    int          m_n    = 0;
    logic [63:0] m_act  = '0;
    logic [63:0] m_pend = '0;
    bit          m_full = 1'b0;
    bit          m_fd   = 1'b0;

    function automatic int cur_pos();
        return (m_n - 1) % FRAME;
    endfunction

    function automatic logic [13:0] model_out();
        logic [13:0] o;
        int p, r, off;
        logic de;
        o = '0;
        if (m_run) begin
            p   = cur_pos();
            r   = p / RP;
            off = p % RP;
            de  = (off >= BT);
            o[13:11] = 3'(r);
            o[10]    = de;
            o[9:2]   = de ? m_act[8*r +: 8] : 8'h00;
        end
        o[1] = m_fd;
        o[0] = ~m_full;
        return o;
    endfunction

    task automatic model_edge();
        bit fe, cap, swp;
        if (!rst_n) begin
            m_run = 1'b0; m_n = 0; m_act = '0; m_full = 1'b0; m_fd = 1'b0;
        end else begin
            fe   = m_run && ena && (cur_pos() == FRAME - 1);
            cap  = board_valid && !m_full;
            swp  = m_full && (!m_run || fe);
            m_fd = fe;
            if (!ena) begin
                m_run = 1'b0; m_n = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_n = 1;
            end else begin
                m_n++;
            end
            if (swp) begin m_act = m_pend; m_full = 1'b0; end
            if (cap) begin m_pend = board_in; m_full = 1'b1; end
        end
    endtask

    // driver: inputs are already set; push expectation, clock, compare
    task automatic step(input string tag);
        logic [13:0] exp_v, obs_v;
        model_edge();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        obs_v = {row_sel, row_ena, cols, frame_done, board_ready};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s t=%0t observed={sel,ena,cols,fd,rdy}=%h expected=%h", tag, $time, obs_v, exp_v);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] exp_s);
        n_cmp++;
        assert (state_dbg === exp_s) else begin
            n_fail++;
            $error("FAIL %s observed state=%0d expected=%0d", tag, state_dbg, exp_s);
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // advance until the current cycle is at frame position pos (bounded)
    task automatic wait_pos(input string tag, input int pos);
        bit found;
        found = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) begin
            if (m_run && cur_pos() == pos) begin
                found = 1'b1;
                break;
            end
            step(tag);
        end
        n_cmp++;
        assert (found) else begin
            n_fail++;
            $error("FAIL %s_timeout observed=not_reached expected=pos_%0d", tag, pos);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        board_valid = 1'b1;
        board_in    = {$urandom, $urandom};

        // reset with ena and valid asserted: nothing captured
        run("reset", 3);
        check_state("reset_state", 2'd0);

        // load diagonal while idle, then scan
        rst_n       = 1'b1;
        ena         = 1'b0;
        board_in    = 64'h8040201008040201;
        step("idle_accept");
        board_valid = 1'b0;
        board_in    = {$urandom, $urandom};
        step("idle_swap");
        step("idle_ready_back");
        ena = 1'b1;
        run("diag_scan", 2 * FRAME);

        // mid-frame accept during row 3 drive
        wait_pos("to_row3", 3 * RP + BT);
        board_valid = 1'b1;
        board_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        step("mid_accept");
        board_valid = 1'b0;
        run("mid_frame", 2 * FRAME);

        // back-pressure: pending full, zero board held valid
        wait_pos("to_row2", 2 * RP + BT + 1);
        board_valid = 1'b1;
        board_in    = 64'hA5A5_5A5A_C3C3_3C3C;
        step("bp_accept");
        board_in = 64'h0;
        run("bp_hold", 20);
        board_valid = 1'b0;
        run("bp_scan", 2 * FRAME);

        // enable abort during row 5 drive
        wait_pos("to_row5", 5 * RP + BT + 1);
        ena = 1'b0;
        step("abort");
        check_state("abort_state", 2'd0);
        run("abort_idle", 3);
        ena = 1'b1;
        run("restart", FRAME + 4);

        // reset coincident with a valid & ready transfer
        board_valid = 1'b1;
        board_in    = {$urandom, $urandom} | 64'h1;
        rst_n       = 1'b0;
        step("rst_handshake");
        rst_n       = 1'b1;
        board_valid = 1'b0;
        run("post_rst", FRAME + 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/led_row_scanner.md
# led_row_scanner

Time-multiplexed row scanner for the 8x8 Game of Life display. Holds the current board, steps a 3-bit row index and row enable that drive the 3-to-8 row decoder directly, and presents the 8 column bits of the selected row. A new generation is accepted through a ready/valid handshake into a one-deep pending buffer. The buffer is swapped in only at a frame boundary, so a frame never shows two generations.

## Interface
- ROW_TICKS, default 1000: clock cycles each row is driven; must be >= 1.
- BLANK_TICKS, default 16: clock cycles of blanking before each row, for ghost suppression; must be >= 1.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- ena  in  1  scan enable; low forces IDLE.
- board_in  in  64  next generation; cell (row r, col c) is bit 8*r+c.
- board_valid  in  1  board_in is valid.
- board_ready  out  1  pending buffer empty; a transfer occurs on any edge where valid & ready.
- row_sel  out  3  row index; feeds the decoder's `in`.
- row_ena  out  1  row drive enable; feeds the decoder's `ena`.
- cols  out  8  column data for row_sel; all zero whenever row_ena=0.
- frame_done  out  1  one-cycle pulse after row 7 finishes its drive period.

## Operation
- All outputs are driven from registers; no combinational input-to-output paths.
- Registers:
  - active[63:0]: displayed board.
  - pending[63:0] with pend_full flag.
  - state: IDLE, BLANK or DRIVE.
  - row[2:0].
  - tick counter, $clog2(max(ROW_TICKS,BLANK_TICKS)+1) bits.
- Reset (rst_n=0 at an edge):
  - state=IDLE, row=0, tick=0, active=0, pend_full=0.
  - Outputs: row_sel=0, row_ena=0, cols=0, frame_done=0, board_ready=1.
  - Reset overrides everything, including mid-frame and mid-handshake. A board presented in the reset cycle is dropped.
- Handshake:
  - board_ready = ~pend_full.
  - On valid & ready: pending <= board_in, pend_full <= 1.
  - board_valid while ready=0 is ignored; the source holds its data.
- Swap (pending -> active, pend_full <= 0) happens in two cases:
  - (a) Any edge where state=IDLE and pend_full=1.
  - (b) The edge ending row 7's DRIVE period while pend_full=1.
  - board_ready rises the cycle after the swap. A capture and a swap never coincide, because ready=0 whenever pend_full=1.
- State machine:
  - IDLE: row_ena=0, cols=0, row_sel=0. If ena=1 at an edge -> BLANK, row=0, tick=0.
  - BLANK: row_ena=0, cols=0, row_sel=row. After BLANK_TICKS cycles in BLANK -> DRIVE, tick=0.
  - DRIVE: row_ena=1, cols=active[8*row+7:8*row], row_sel=row. After ROW_TICKS cycles in DRIVE -> BLANK, row=row+1 (7 wraps to 0), tick=0. Leaving row 7 also sets frame_done=1 for the next cycle only, and performs swap (b) if pending.
  - Any state with ena=0 at an edge -> IDLE next cycle (row=0, outputs blanked). frame_done does not pulse on this abort.
- cols reads the active register, so an accepted board never appears mid-frame.

## Timing
- Frame period is 8*(BLANK_TICKS+ROW_TICKS) cycles. Rows are scanned 0..7 in order.
- Edge 0 is the first edge with rst_n=1 and ena=1.
  - Cycles 1..BLANK_TICKS: BLANK, row 0.
  - Cycles BLANK_TICKS+1..BLANK_TICKS+ROW_TICKS: DRIVE, row 0.
- frame_done is high in the first BLANK cycle of row 0 of the next frame. The newly swapped board first drives in that frame's row 0 DRIVE period.
- Handshake latency: capture at edge k gives board_ready=0 from cycle k+1 until the cycle after the swap.
- Latency from IDLE: a valid board accepted while IDLE swaps at the following edge, so ready returns 2 cycles after the accept.

## Test plan
Use ROW_TICKS=4, BLANK_TICKS=2 (frame = 48 cycles).

- Reset check: hold rst_n=0 for 3 cycles, with ena=1 and board_valid=1 during them. Required: row_ena=0, cols=0, row_sel=0, frame_done=0, board_ready=1; nothing captured.
- Load a board while IDLE: board_in=64'h8040201008040201 (diagonal), then ena=1. Required:
  - board_ready goes low, then high 2 cycles after the accept.
  - Row r drives cols=8'h01<<r with row_ena=1 for exactly 4 cycles, preceded by 2 cycles of cols=0 and row_ena=0.
  - frame_done pulses once every 48 cycles.
- Mid-frame accept: during row 3 DRIVE, present 64'hFFFF_FFFF_FFFF_FFFF. Required:
  - board_ready=0 from the next cycle.
  - Rows 4..7 still show the diagonal.
  - The swap happens with the frame_done pulse; ready=1 the cycle after.
  - The next frame shows cols=8'hFF for all rows.
- Back-pressure: with pend_full=1, drive board_valid=1 with 64'h0 for 20 cycles. Required: no capture; the displayed next frame is the earlier pending board, not 0.
- Enable abort: drop ena during row 5 DRIVE. Required: the next cycle is IDLE with row_ena=0, row_sel=0, and no frame_done. Re-raising ena restarts at row 0 BLANK.
- Reset mid-handshake: assert rst_n=0 for 1 cycle in the same cycle as a valid & ready transfer. Required: pend_full=0, active=0, cols=0 after release.
